// File: rtl/axi4_lite_if_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus-width defaults and the
// byte-strobe merge used by register banks.
package axi4_lite_if_pkg;

    localparam int AXI4_LITE_ADDR_W_DEFAULT = 32;
    localparam int AXI4_LITE_DATA_W_DEFAULT = 32;
    localparam int AXI4_LITE_STRB_W_DEFAULT = AXI4_LITE_DATA_W_DEFAULT / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4_resp_t;

    typedef logic [AXI4_LITE_DATA_W_DEFAULT-1:0] axi4_data_t;
    typedef logic [AXI4_LITE_STRB_W_DEFAULT-1:0] axi4_strb_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic axi4_data_t apply_wstrb(
        input axi4_data_t old_val,
        input axi4_data_t new_val,
        input axi4_strb_t strb
    );
        axi4_data_t merged;
        merged = old_val;
        for (int b = 0; b < AXI4_LITE_STRB_W_DEFAULT; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with slave-side and master-side views.
interface axi4_lite_if #(
    parameter int ADDR_W = axi4_lite_if_pkg::AXI4_LITE_ADDR_W_DEFAULT,
    parameter int DATA_W = axi4_lite_if_pkg::AXI4_LITE_DATA_W_DEFAULT
);

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slv_port (
        input  awaddr,
        input  awprot,
        input  awvalid,
        output awready,
        input  wdata,
        input  wstrb,
        input  wvalid,
        output wready,
        output bresp,
        output bvalid,
        input  bready,
        input  araddr,
        input  arprot,
        input  arvalid,
        output arready,
        output rdata,
        output rresp,
        output rvalid,
        input  rready
    );

    modport mst_port (
        output awaddr,
        output awprot,
        output awvalid,
        input  awready,
        output wdata,
        output wstrb,
        output wvalid,
        input  wready,
        input  bresp,
        input  bvalid,
        output bready,
        output araddr,
        output arprot,
        output arvalid,
        input  arready,
        input  rdata,
        input  rresp,
        input  rvalid,
        output rready
    );

endinterface

// File: rtl/axi4_lite_slv_reg_bank.sv
// Register array with one byte-strobed write port and one combinational
// read port; all registers clear on reset.
module axi4_lite_slv_reg_bank
    import axi4_lite_if_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                                i_clk,
    input  logic                                i_sync_rst,
    input  logic                                wr_en,
    input  logic [IDX_W-1:0]                    wr_idx,
    input  logic [AXI4_LITE_DATA_W_DEFAULT-1:0] wr_data,
    input  logic [AXI4_LITE_STRB_W_DEFAULT-1:0] wr_strb,
    input  logic [IDX_W-1:0]                    rd_idx,
    output logic [AXI4_LITE_DATA_W_DEFAULT-1:0] rd_data
);

    axi4_data_t regs_q [NUM_REGS];
    axi4_data_t regs_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wr_idx] = apply_wstrb(regs_q[wr_idx], wr_data, wr_strb);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd_data = regs_q[rd_idx];

endmodule

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave register file: independent write (IDLE->RESP) and read
// (IDLE->DATA) handshake FSMs in front of a byte-strobed register bank.
module axi4_lite_slv_reg_file
    import axi4_lite_if_pkg::*;
#(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = AXI4_LITE_ADDR_W_DEFAULT,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = AXI4_LITE_DATA_W_DEFAULT,
    parameter int NUM_REGS                 = 4
) (
    input logic           i_clk,
    input logic           i_sync_rst,
    axi4_lite_if.slv_port if_s_axi4_lite
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0] ADDR_LIMIT =
        AXI4_LITE_ADDR_BIT_WIDTH'(4 * NUM_REGS);

    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_RESP = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    logic [0:0] wr_state_q, wr_state_d;
    logic       awready_q, awready_d;
    logic       bvalid_q, bvalid_d;
    axi4_resp_t bresp_q, bresp_d;

    logic [0:0] rd_state_q, rd_state_d;
    logic       arready_q, arready_d;
    logic       rvalid_q, rvalid_d;
    axi4_resp_t rresp_q, rresp_d;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;

    logic       wr_hs;
    logic       rd_hs;
    logic       aw_addr_ok;
    logic       ar_addr_ok;
    logic       bank_wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [AXI4_LITE_DATA_W_DEFAULT-1:0] bank_rd_data;
    logic       unused_prot;

    // Protection bits carry no meaning for this register block.
    assign unused_prot = ^{if_s_axi4_lite.awprot, if_s_axi4_lite.arprot};

    assign aw_addr_ok = (if_s_axi4_lite.awaddr < ADDR_LIMIT);
    assign ar_addr_ok = (if_s_axi4_lite.araddr < ADDR_LIMIT);
    assign wr_idx     = if_s_axi4_lite.awaddr[IDX_W+1:2];
    assign rd_idx     = if_s_axi4_lite.araddr[IDX_W+1:2];

    // awready and wready are one flop, so both channels handshake on the same edge.
    assign wr_hs      = awready_q && if_s_axi4_lite.awvalid && if_s_axi4_lite.wvalid;
    assign rd_hs      = arready_q && if_s_axi4_lite.arvalid;
    assign bank_wr_en = wr_hs && aw_addr_ok;

    axi4_lite_slv_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_reg_bank (
        .i_clk      (i_clk),
        .i_sync_rst (i_sync_rst),
        .wr_en      (bank_wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (if_s_axi4_lite.wdata),
        .wr_strb    (if_s_axi4_lite.wstrb),
        .rd_idx     (rd_idx),
        .rd_data    (bank_rd_data)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_hs) begin
                    wr_state_d = WR_RESP;
                    bvalid_d   = 1'b1;
                    bresp_d    = aw_addr_ok ? OKAY : SLVERR;
                end else begin
                    awready_d = if_s_axi4_lite.awvalid && if_s_axi4_lite.wvalid &&
                                !bvalid_q && !awready_q;
                end
            end
            WR_RESP: begin
                if (if_s_axi4_lite.bready) begin
                    wr_state_d = WR_IDLE;
                    bvalid_d   = 1'b0;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read data is captured from the bank before any same-edge write lands.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_hs) begin
                    rd_state_d = RD_DATA;
                    rvalid_d   = 1'b1;
                    rresp_d    = ar_addr_ok ? OKAY : SLVERR;
                    rdata_d    = ar_addr_ok ? bank_rd_data : '0;
                end
            end
            RD_DATA: begin
                if (if_s_axi4_lite.rready) begin
                    rd_state_d = RD_IDLE;
                    rvalid_d   = 1'b0;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        arready_d = (rd_state_d == RD_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign if_s_axi4_lite.awready = awready_q;
    assign if_s_axi4_lite.wready  = awready_q;
    assign if_s_axi4_lite.bvalid  = bvalid_q;
    assign if_s_axi4_lite.bresp   = bresp_q;
    assign if_s_axi4_lite.arready = arready_q;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rresp   = rresp_q;
    assign if_s_axi4_lite.rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Directed bench for axi4_lite_slv_reg_file: vector table plus hand-written
// backpressure, same-edge read/write and mid-transaction reset sequences.
module tb_axi4_lite_slv_reg_file;

    logic i_clk = 1'b0;
    logic i_sync_rst;
    always #5 i_clk = ~i_clk;

    axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi_if ();

    axi4_lite_slv_reg_file #(
        .AXI4_LITE_ADDR_BIT_WIDTH (32),
        .AXI4_LITE_DATA_BIT_WIDTH (32),
        .NUM_REGS                 (4)
    ) dut (
        .i_clk          (i_clk),
        .i_sync_rst     (i_sync_rst),
        .if_s_axi4_lite (axi_if)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [1:0] resp,
                                input logic [31:0] rdata);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.resp = resp; v.rdata = rdata;
        return v;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output int lat);
        int n;
        axi_if.awaddr  = addr;
        axi_if.wdata   = data;
        axi_if.wstrb   = strb;
        axi_if.awvalid = 1'b1;
        axi_if.wvalid  = 1'b1;
        axi_if.bready  = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end
        while (!(axi_if.awready && axi_if.wready) && n < 20);
        @(posedge i_clk); #1;
        axi_if.awvalid = 1'b0;
        axi_if.wvalid  = 1'b0;
        lat = 0;
        do begin @(negedge i_clk); lat++; end
        while (!axi_if.bvalid && lat < 20);
        if (n >= 20) lat = -1;
        resp = axi_if.bresp;
        @(posedge i_clk); #1;
        axi_if.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int n;
        axi_if.araddr  = addr;
        axi_if.arvalid = 1'b1;
        axi_if.rready  = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end
        while (!axi_if.arready && n < 20);
        @(posedge i_clk); #1;
        axi_if.arvalid = 1'b0;
        lat = 0;
        do begin @(negedge i_clk); lat++; end
        while (!axi_if.rvalid && lat < 20);
        if (n >= 20) lat = -1;
        data = axi_if.rdata;
        resp = axi_if.rresp;
        @(posedge i_clk); #1;
        axi_if.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
        int          n;

        vecs.push_back(mk(1'b0, 32'h0,        32'h0,        4'h0, 2'b00, 32'h0));
        vecs.push_back(mk(1'b0, 32'h4,        32'h0,        4'h0, 2'b00, 32'h0));
        vecs.push_back(mk(1'b0, 32'h8,        32'h0,        4'h0, 2'b00, 32'h0));
        vecs.push_back(mk(1'b0, 32'hC,        32'h0,        4'h0, 2'b00, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0,        32'h12345678, 4'hF, 2'b00, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4,        32'h87654321, 4'hF, 2'b00, 32'h0));
        vecs.push_back(mk(1'b1, 32'h8,        32'hABCDEF01, 4'hF, 2'b00, 32'h0));
        vecs.push_back(mk(1'b1, 32'hC,        32'h10FEDCBA, 4'hF, 2'b00, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0,        32'h0,        4'h0, 2'b00, 32'h12345678));
        vecs.push_back(mk(1'b0, 32'h4,        32'h0,        4'h0, 2'b00, 32'h87654321));
        vecs.push_back(mk(1'b0, 32'h8,        32'h0,        4'h0, 2'b00, 32'hABCDEF01));
        vecs.push_back(mk(1'b0, 32'hC,        32'h0,        4'h0, 2'b00, 32'h10FEDCBA));
        vecs.push_back(mk(1'b1, 32'h4,        32'hFFFFFFFF, 4'h5, 2'b00, 32'h0));
        vecs.push_back(mk(1'b0, 32'h4,        32'h0,        4'h0, 2'b00, 32'h87FF43FF));
        vecs.push_back(mk(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 2'b10, 32'h0));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        4'h0, 2'b10, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0,        32'h0,        4'h0, 2'b00, 32'h12345678));
        vecs.push_back(mk(1'b0, 32'h4,        32'h0,        4'h0, 2'b00, 32'h87FF43FF));
        vecs.push_back(mk(1'b0, 32'h8,        32'h0,        4'h0, 2'b00, 32'hABCDEF01));
        vecs.push_back(mk(1'b0, 32'hC,        32'h0,        4'h0, 2'b00, 32'h10FEDCBA));
        vecs.push_back(mk(1'b1, 32'hB,        32'h5555AAAA, 4'hF, 2'b00, 32'h0));
        vecs.push_back(mk(1'b0, 32'h8,        32'h0,        4'h0, 2'b00, 32'h5555AAAA));
        vecs.push_back(mk(1'b1, 32'hFFFFFFFC, 32'h00000001, 4'hF, 2'b10, 32'h0));
        vecs.push_back(mk(1'b0, 32'hC,        32'h0,        4'h0, 2'b00, 32'h10FEDCBA));
        vecs.push_back(mk(1'b1, 32'h0,        32'hFFFFFFFF, 4'h0, 2'b00, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0,        32'h0,        4'h0, 2'b00, 32'h12345678));

        i_sync_rst     = 1'b1;
        axi_if.awaddr  = '0; axi_if.awprot = '0; axi_if.awvalid = 1'b0;
        axi_if.wdata   = '0; axi_if.wstrb  = '0; axi_if.wvalid  = 1'b0;
        axi_if.bready  = 1'b0;
        axi_if.araddr  = '0; axi_if.arprot = '0; axi_if.arvalid = 1'b0;
        axi_if.rready  = 1'b0;

        for (int c = 0; c < 20; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check($sformatf("rst_handshake_c%0d", c),
                  {27'd0, axi_if.awready, axi_if.wready, axi_if.bvalid,
                   axi_if.arready, axi_if.rvalid}, 32'h0);
        end
        check("rst_bresp_rresp", {28'd0, axi_if.bresp, axi_if.rresp}, 32'h0);
        check("rst_rdata", axi_if.rdata, 32'h0);
        @(posedge i_clk); #1;
        i_sync_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("post_rst_arready", {31'd0, axi_if.arready}, 32'h1);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
                check($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].resp});
                check($sformatf("vec%0d_wlat", i), lat, 32'd1);
            end else begin
                axi_read(vecs[i].addr, rdata, resp, lat);
                check($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].resp});
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
                check($sformatf("vec%0d_rlat", i), lat, 32'd1);
            end
        end

        // Write response backpressure with a second write waiting.
        axi_if.bready  = 1'b0;
        axi_if.awaddr  = 32'h0; axi_if.wdata = 32'hCAFEF00D; axi_if.wstrb = 4'hF;
        axi_if.awvalid = 1'b1; axi_if.wvalid = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!axi_if.awready && n < 20);
        check("bp_w_awready_seen", {31'd0, axi_if.awready}, 32'h1);
        @(posedge i_clk); #1;
        axi_if.awaddr = 32'h4; axi_if.wdata = 32'h11111111;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check($sformatf("bp_w_bvalid_c%0d", c), {31'd0, axi_if.bvalid}, 32'h1);
            check($sformatf("bp_w_bresp_c%0d", c), {30'd0, axi_if.bresp}, 32'h0);
            check($sformatf("bp_w_awready_c%0d", c), {31'd0, axi_if.awready}, 32'h0);
        end
        axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
        axi_if.bready  = 1'b1;
        @(posedge i_clk); #1;
        axi_if.bready = 1'b0;
        @(negedge i_clk);
        check("bp_w_bvalid_done", {31'd0, axi_if.bvalid}, 32'h0);
        axi_read(32'h4, rdata, resp, lat);
        check("bp_w_second_not_taken", rdata, 32'h87FF43FF);

        // Read response backpressure with a second read waiting.
        axi_if.rready  = 1'b0;
        axi_if.araddr  = 32'h0; axi_if.arvalid = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!axi_if.arready && n < 20);
        check("bp_r_arready_seen", {31'd0, axi_if.arready}, 32'h1);
        @(posedge i_clk); #1;
        axi_if.araddr = 32'h4;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check($sformatf("bp_r_rvalid_c%0d", c), {31'd0, axi_if.rvalid}, 32'h1);
            check($sformatf("bp_r_rdata_c%0d", c), axi_if.rdata, 32'hCAFEF00D);
            check($sformatf("bp_r_rresp_c%0d", c), {30'd0, axi_if.rresp}, 32'h0);
            check($sformatf("bp_r_arready_c%0d", c), {31'd0, axi_if.arready}, 32'h0);
        end
        axi_if.arvalid = 1'b0;
        axi_if.rready  = 1'b1;
        @(posedge i_clk); #1;
        axi_if.rready = 1'b0;
        @(negedge i_clk);
        check("bp_r_rvalid_done", {31'd0, axi_if.rvalid}, 32'h0);
        check("bp_r_arready_back", {31'd0, axi_if.arready}, 32'h1);

        // Write and read handshake on the same edge to the same register.
        axi_if.awaddr  = 32'h8; axi_if.wdata = 32'h0BADCAFE; axi_if.wstrb = 4'hF;
        axi_if.awvalid = 1'b1; axi_if.wvalid = 1'b1;
        axi_if.bready  = 1'b1; axi_if.rready = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!axi_if.awready && n < 20);
        check("same_edge_arready", {31'd0, axi_if.arready}, 32'h1);
        axi_if.araddr = 32'h8; axi_if.arvalid = 1'b1;
        @(posedge i_clk); #1;
        axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0; axi_if.arvalid = 1'b0;
        @(negedge i_clk);
        check("same_edge_bvalid", {31'd0, axi_if.bvalid}, 32'h1);
        check("same_edge_rvalid", {31'd0, axi_if.rvalid}, 32'h1);
        check("same_edge_rdata_old", axi_if.rdata, 32'h5555AAAA);
        @(posedge i_clk); #1;
        axi_if.bready = 1'b0; axi_if.rready = 1'b0;
        axi_read(32'h8, rdata, resp, lat);
        check("same_edge_rdata_new", rdata, 32'h0BADCAFE);

        // Reset while a write response is pending.
        axi_if.bready  = 1'b0;
        axi_if.awaddr  = 32'hC; axi_if.wdata = 32'h33333333; axi_if.wstrb = 4'hF;
        axi_if.awvalid = 1'b1; axi_if.wvalid = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!axi_if.awready && n < 20);
        @(posedge i_clk); #1;
        axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
        @(negedge i_clk);
        check("rst_mid_bvalid_before", {31'd0, axi_if.bvalid}, 32'h1);
        i_sync_rst = 1'b1;
        @(posedge i_clk); #1;
        check("rst_mid_bvalid_after", {31'd0, axi_if.bvalid}, 32'h0);
        check("rst_mid_arready_after", {31'd0, axi_if.arready}, 32'h0);
        @(posedge i_clk); #1;
        i_sync_rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            axi_read(32'(4 * r), rdata, resp, lat);
            check($sformatf("rst_mid_reg%0d", r), rdata, 32'h0);
            check($sformatf("rst_mid_resp%0d", r), {30'd0, resp}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
